// File: rtl/pwm_pkg.sv
// Shared types, constants and helpers for the PWM ramp sequencer.
package pwm_pkg;

    localparam int unsigned DW       = 16;
    localparam int unsigned RES_BASE = 12;
    localparam int unsigned RES_MAX  = 4;

    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StRampUp = 2'd1,
        StHold   = 2'd2,
        StRampDn = 2'd3
    } pwm_state_e;

    typedef struct packed {
        logic [DW-1:0] target;
        logic [DW-1:0] step;
        logic [3:0]    prd;
        logic [2:0]    res;
        logic          pol;
    } pwm_cfg_t;

    function automatic logic [2:0] res_sanitize(input logic [2:0] res);
        return (32'(res) > RES_MAX) ? 3'd0 : res;
    endfunction

    // Largest duty code representable at the given resolution code.
    function automatic logic [DW-1:0] res_lim(input logic [2:0] res);
        logic [DW:0] one_hot;
        logic [DW:0] lim_x;
        one_hot = {{DW{1'b0}}, 1'b1} << (RES_BASE + 32'(res_sanitize(res)));
        lim_x   = one_hot - {{DW{1'b0}}, 1'b1};
        return lim_x[DW-1:0];
    endfunction

endpackage

// File: rtl/pwm_step_calc.sv
// Combinational next-duty: one saturating step of cur toward tgt, bounded by [0, lim].
module pwm_step_calc
    import pwm_pkg::*;
(
    input  logic [DW-1:0] cur_i,
    input  logic [DW-1:0] tgt_i,
    input  logic [DW-1:0] step_i,
    input  logic [DW-1:0] lim_i,
    output logic [DW-1:0] next_o,
    output logic          reached_o
);

    logic [DW:0] cur_x, tgt_x, step_x, lim_x, diff, acc;

    assign cur_x  = {1'b0, cur_i};
    assign tgt_x  = {1'b0, tgt_i};
    assign step_x = {1'b0, step_i};
    assign lim_x  = {1'b0, lim_i};

    always_comb begin
        next_o    = cur_i;
        reached_o = 1'b0;
        diff      = '0;
        acc       = '0;
        if (tgt_x >= cur_x) begin
            diff = tgt_x - cur_x;
            acc  = cur_x + step_x;
            if (step_i == '0 || diff <= step_x) begin
                next_o    = tgt_i;
                reached_o = 1'b1;
            end else if (acc > lim_x) begin
                next_o = lim_i;
            end else begin
                next_o = acc[DW-1:0];
            end
        end else begin
            diff = cur_x - tgt_x;
            acc  = cur_x - step_x;
            if (step_i == '0 || diff <= step_x) begin
                next_o    = tgt_i;
                reached_o = 1'b1;
            end else if (acc[DW]) begin
                next_o = '0;
            end else begin
                next_o = acc[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_seq.sv
// PWM ramp sequencer: shadows config, applies it on period boundaries and ramps duty
// toward the clamped target (or toward 0 when disabled).
module pwm_ramp_seq
    import pwm_pkg::*;
(
    input  logic          core_clk,
    input  logic          core_rst_n,
    input  logic          enable,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_target,
    input  logic [DW-1:0] cfg_step,
    input  logic [3:0]    cfg_prd,
    input  logic [2:0]    cfg_res,
    input  logic          cfg_pol,
    input  logic          period_end,
    output logic [DW-1:0] data,
    output logic [3:0]    PWM_PRD,
    output logic [2:0]    PWM_RES,
    output logic          PWM_POL,
    output logic          busy,
    output logic          done
);

    pwm_state_e    state_q, state_d;
    pwm_cfg_t      pend_q, pend_d;
    pwm_cfg_t      act_q, act_d;
    pwm_cfg_t      cfg_in;
    logic          pend_flag_q, pend_flag_d;
    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [DW-1:0] lim, tgt, base, calc_tgt, calc_next;
    logic          calc_reached;

    always_comb begin
        cfg_in        = '0;
        cfg_in.target = cfg_target;
        cfg_in.step   = cfg_step;
        cfg_in.prd    = cfg_prd;
        cfg_in.res    = res_sanitize(cfg_res);
        cfg_in.pol    = cfg_pol;
    end

    // Shadow/apply: a cfg arriving on period_end bypasses the pending set entirely.
    always_comb begin
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        act_d       = act_q;
        if (period_end) begin
            pend_flag_d = 1'b0;
            if (cfg_valid) begin
                act_d = cfg_in;
            end else if (pend_flag_q) begin
                act_d = pend_q;
            end
        end else if (cfg_valid) begin
            pend_d      = cfg_in;
            pend_flag_d = 1'b1;
        end
    end

    // Step math uses the configuration that is active after this edge.
    always_comb begin
        lim      = res_lim(act_d.res);
        tgt      = (act_d.target > lim) ? lim : act_d.target;
        base     = (data_q > lim) ? lim : data_q;
        calc_tgt = enable ? tgt : '0;
    end

    pwm_step_calc u_step_calc (
        .cur_i     (base),
        .tgt_i     (calc_tgt),
        .step_i    (act_d.step),
        .lim_i     (lim),
        .next_o    (calc_next),
        .reached_o (calc_reached)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (state_q == StOff && !enable) begin
            data_d = '0;
        end else if (period_end) begin
            data_d = calc_next;
            if (enable) begin
                state_d = calc_reached ? StHold : StRampUp;
                done_d  = calc_reached && (state_q != StHold || calc_next != data_q);
            end else begin
                state_d = calc_reached ? StOff : StRampDn;
                done_d  = calc_reached;
            end
        end else if (!enable) begin
            state_d = StRampDn;
        end
        busy_d = (state_d == StRampUp) || (state_d == StRampDn);
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q     <= StOff;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            act_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            act_q       <= act_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data    = data_q;
    assign PWM_PRD = act_q.prd;
    assign PWM_RES = act_q.res;
    assign PWM_POL = act_q.pol;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
